// File: rtl/muu_value_set512_pkg.sv
// Shared definitions for the value-set (write) path: header layout, beat geometry, FSM states, status codes.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package muu_value_set512_pkg;

    localparam int KEY_W          = 128;
    localparam int HDR_W          = 42;
    localparam int META_W         = 96;
    localparam int MEM_W          = 512;
    localparam int MAX_LEN_WORDS  = 1023;

    // Header field offsets (within the header slice of the request)
    localparam int ADDR_OFS       = 0;
    localparam int ADDR_W         = 32;
    localparam int LEN_OFS        = 32;
    localparam int LEN_W          = 10;

    // Beat geometry: 512-bit beat = 8 lanes of 64-bit words
    localparam int WORDS_PER_BEAT = 8;
    localparam int LANE_W         = 64;
    localparam int BEAT_CNT_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_DATA  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_CPL   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        STATUS_OK      = 2'd0,
        STATUS_REJECT  = 2'd1,
        STATUS_LEN_ERR = 2'd2
    } status_t;

    // ceil(len / 8) in 11-bit arithmetic; 1023 words -> 128 beats, so 8 bits always suffice
    function automatic logic [BEAT_CNT_W-1:0] beat_count(input logic [LEN_W-1:0] len);
        logic [LEN_W:0] sum;
        sum = {1'b0, len} + 11'd7;
        return sum[LEN_W:3];
    endfunction

endpackage

// File: rtl/muu_beat_mask512.sv
// Zeroes the 64-bit lanes at index >= (len mod 8) on the final beat of a value.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; follows whatever beat is presented.
module muu_beat_mask512
    import muu_value_set512_pkg::*;
(
    input  logic [MEM_W-1:0] beat_in,
    input  logic [2:0]       len_mod,
    input  logic             final_beat,
    output logic [MEM_W-1:0] beat_out
);

    // Lanes past the end of the value carry whatever the network sent; clear them
    always_comb begin
        beat_out = beat_in;
        if (final_beat && (len_mod != 3'd0)) begin
            for (int i = 0; i < WORDS_PER_BEAT; i++) begin
                if (3'(i) >= len_mod) begin
                    beat_out[i*LANE_W +: LANE_W] = '0;
                end
            end
        end
    end

endmodule

// File: rtl/muu_value_set512.sv
// Write-side value path: request -> one memory write command + value beats -> completion {meta, status}.
// Latency: command 1 cycle after request accept; each beat 1 cycle through a one-deep output register.
// Backpressure: wr_data_ready stalls value_ready with no bubble; cpl_ready holds off new requests.
// Optional build macro MUU_SET_LENCHECK_EN: check value_last against the computed beat count.
module muu_value_set512
    import muu_value_set512_pkg::*;
#(
    parameter int KEY_WIDTH    = KEY_W,
    parameter int HEADER_WIDTH = HDR_W,
    parameter int META_WIDTH   = META_W,
    parameter int MEMORY_WIDTH = MEM_W,
    parameter int MAX_LEN      = MAX_LEN_WORDS
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [KEY_WIDTH+HEADER_WIDTH+META_WIDTH-1:0] input_data,
    input  logic                                      input_valid,
    output logic                                      input_ready,
    input  logic [MEMORY_WIDTH-1:0]                   value_data,
    input  logic                                      value_valid,
    input  logic                                      value_last,
    output logic                                      value_ready,
    output logic [31:0]                               wr_cmd_addr,
    output logic [9:0]                                wr_cmd_len,
    output logic                                      wr_cmd_valid,
    input  logic                                      wr_cmd_ready,
    output logic [MEMORY_WIDTH-1:0]                   wr_data,
    output logic                                      wr_data_valid,
    output logic                                      wr_data_last,
    input  logic                                      wr_data_ready,
    output logic [META_WIDTH+63:0]                    cpl_data,
    output logic                                      cpl_valid,
    input  logic                                      cpl_ready
);

    localparam int             HDR_OFS   = KEY_WIDTH + META_WIDTH;
    localparam logic [LEN_W:0] MAX_LEN_X = 11'(MAX_LEN);

    state_t                  state_q, state_d;
    logic [META_WIDTH-1:0]   meta_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [LEN_W-1:0]        len_q;
    logic [BEAT_CNT_W-1:0]   beats_left_q;
    status_t                 status_q;
    logic                    pad_q, discard_q, wr_done_q;

    logic [META_WIDTH-1:0]   in_meta;
    logic [ADDR_W-1:0]       in_addr;
    logic [LEN_W-1:0]        in_len;
    logic                    in_reject;
    logic                    unused_key;

    logic                    in_fire, cmd_fire, val_fire, wr_fire, cpl_fire;
    logic                    slot_free, final_beat, take, pad_load, load, drain_take;
    logic                    early_last, miss_last, drop_last;
    logic                    discard_d, wr_done_d;
    logic [MEMORY_WIDTH-1:0] masked_beat, load_beat;

    // Request field extraction: {header, meta, key}; the key itself is not needed on the write path
    assign in_meta    = input_data[KEY_WIDTH +: META_WIDTH];
    assign in_addr    = input_data[HDR_OFS + ADDR_OFS +: ADDR_W];
    assign in_len     = input_data[HDR_OFS + LEN_OFS +: LEN_W];
    assign unused_key = ^input_data[KEY_WIDTH-1:0];
    assign in_reject  = (in_addr == '0) || ({1'b0, in_len} > MAX_LEN_X);

    assign in_fire    = input_valid & input_ready;
    assign cmd_fire   = wr_cmd_valid & wr_cmd_ready;
    assign val_fire   = value_valid & value_ready;
    assign wr_fire    = wr_data_valid & wr_data_ready;
    assign cpl_fire   = cpl_valid & cpl_ready;

    // Output register can take a beat when empty or draining this cycle
    assign slot_free  = ~wr_data_valid | wr_data_ready;
    assign final_beat = (beats_left_q == 8'd1);
    assign take       = val_fire & (state_q == ST_DATA) & ~discard_q;
    assign pad_load   = pad_q & slot_free & (beats_left_q != '0) & (state_q == ST_DATA);
    assign load       = take | pad_load;
    assign drain_take = val_fire & (state_q == ST_DRAIN);

`ifdef MUU_SET_LENCHECK_EN
    assign early_last = take & value_last & ~final_beat;
    assign miss_last  = take & final_beat & ~value_last;
    assign drop_last  = discard_q & val_fire & value_last;
`else
    logic unused_last;
    assign unused_last = value_last;
    assign early_last  = 1'b0;
    assign miss_last   = 1'b0;
    assign drop_last   = 1'b0;
`endif

    assign discard_d = (discard_q & ~drop_last) | miss_last;
    assign wr_done_d = wr_done_q | (wr_fire & wr_data_last);

    muu_beat_mask512 u_mask (
        .beat_in    (value_data),
        .len_mod    (len_q[2:0]),
        .final_beat (final_beat),
        .beat_out   (masked_beat)
    );

    // Padded beats after an early value_last are all-zero
    assign load_beat = pad_load ? '0 : masked_beat;

    // Value beats are consumed only in DATA (into the output register, or discarded) and DRAIN
    always_comb begin
        value_ready = 1'b0;
        case (state_q)
            ST_DATA:  value_ready = (slot_free & (beats_left_q != '0) & ~pad_q) | discard_q;
            ST_DRAIN: value_ready = 1'b1;
            default:  value_ready = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: one command + data phase per request, or drain for rejected ones
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    if (in_len == '0)   state_d = ST_CPL;
                    else if (in_reject) state_d = ST_DRAIN;
                    else                state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (cmd_fire) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (wr_done_d && !discard_d) state_d = ST_CPL;
            end
            ST_DRAIN: begin
                if (drain_take && final_beat) state_d = ST_CPL;
            end
            ST_CPL: begin
                if (cpl_fire) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs are registered images of the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            input_ready  <= 1'b0;
            wr_cmd_valid <= 1'b0;
            cpl_valid    <= 1'b0;
        end else begin
            input_ready  <= (state_d == ST_IDLE);
            wr_cmd_valid <= (state_d == ST_CMD);
            cpl_valid    <= (state_d == ST_CPL);
        end
    end

    // Request context, beat countdown and framing-error tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q       <= '0;
            addr_q       <= '0;
            len_q        <= '0;
            beats_left_q <= '0;
            status_q     <= STATUS_OK;
            pad_q        <= 1'b0;
            discard_q    <= 1'b0;
            wr_done_q    <= 1'b0;
        end else if (in_fire) begin
            meta_q       <= in_meta;
            addr_q       <= in_addr;
            len_q        <= in_len;
            // Count already tops out at 128 for a 10-bit length, which bounds the drain too
            beats_left_q <= beat_count(in_len);
            status_q     <= ((in_len != '0) && in_reject) ? STATUS_REJECT : STATUS_OK;
            pad_q        <= 1'b0;
            discard_q    <= 1'b0;
            wr_done_q    <= 1'b0;
        end else begin
            if (load || drain_take) beats_left_q <= beats_left_q - 8'd1;
            if (early_last)         pad_q        <= 1'b1;
            if (early_last || miss_last) status_q <= STATUS_LEN_ERR;
            discard_q <= discard_d;
            wr_done_q <= wr_done_d;
        end
    end

    // One-deep write-data register: refill in the same cycle memory takes the current beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_data       <= '0;
            wr_data_valid <= 1'b0;
            wr_data_last  <= 1'b0;
        end else if (load) begin
            wr_data       <= load_beat;
            wr_data_valid <= 1'b1;
            wr_data_last  <= final_beat;
        end else if (wr_fire) begin
            wr_data_valid <= 1'b0;
            wr_data_last  <= 1'b0;
        end
    end

    assign wr_cmd_addr = addr_q;
    assign wr_cmd_len  = len_q;
    assign cpl_data    = {meta_q, 22'h0, len_q, 14'h0, status_q, 16'hffff};

endmodule

// File: tb/tb_muu_value_set512.sv
// Bench for muu_value_set512: vector table plus randomized requests against a word-level model.
// Latency: n/a.
// Backpressure: memory and completion readiness are randomized in the random phase.
module tb_muu_value_set512;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [265:0]   input_data;
    logic           input_valid;
    logic           input_ready;
    logic [511:0]   value_data;
    logic           value_valid;
    logic           value_last;
    logic           value_ready;
    logic [31:0]    wr_cmd_addr;
    logic [9:0]     wr_cmd_len;
    logic           wr_cmd_valid;
    logic           wr_cmd_ready;
    logic [511:0]   wr_data;
    logic           wr_data_valid;
    logic           wr_data_last;
    logic           wr_data_ready;
    logic [159:0]   cpl_data;
    logic           cpl_valid;
    logic           cpl_ready;

    int checks   = 0;
    int failures = 0;

    logic [511:0] vals [128];

    typedef struct {
        logic [31:0] addr;
        int          len;
        int          early;   // beat index carrying an early value_last, -1 = none
        bit          rnd;
        int          hold;
        int          st;
        int          ncmd;
        int          nbeat;
        int          ncons;
    } vec_t;

    vec_t vecs[$];

    muu_value_set512 dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .input_data    (input_data),
        .input_valid   (input_valid),
        .input_ready   (input_ready),
        .value_data    (value_data),
        .value_valid   (value_valid),
        .value_last    (value_last),
        .value_ready   (value_ready),
        .wr_cmd_addr   (wr_cmd_addr),
        .wr_cmd_len    (wr_cmd_len),
        .wr_cmd_valid  (wr_cmd_valid),
        .wr_cmd_ready  (wr_cmd_ready),
        .wr_data       (wr_data),
        .wr_data_valid (wr_data_valid),
        .wr_data_last  (wr_data_last),
        .wr_data_ready (wr_data_ready),
        .cpl_data      (cpl_data),
        .cpl_valid     (cpl_valid),
        .cpl_ready     (cpl_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // Reference: words with global index >= len are zero; beats after an early last are zero
    function automatic logic [511:0] exp_beat(input int i, input int len, input int early);
        logic [511:0] b;
        b = '0;
        if (early >= 0 && i > early) return b;
        for (int l = 0; l < 8; l++) begin
            if (i * 8 + l < len) b[l*64 +: 64] = vals[i][l*64 +: 64];
        end
        return b;
    endfunction

    task automatic model(input logic [31:0] addr, input int len, input int early,
                         output int st, output int ncmd, output int nbeat, output int ncons);
        int beats;
        beats = (len + 7) / 8;
        if (len == 0) begin
            st = 0; ncmd = 0; nbeat = 0; ncons = 0;
        end else if (addr == 0 || len > 1023) begin
            st = 1; ncmd = 0; nbeat = 0; ncons = beats;
        end else if (early >= 0) begin
            st = 2; ncmd = 1; nbeat = beats; ncons = early + 1;
        end else begin
            st = 0; ncmd = 1; nbeat = beats; ncons = beats;
        end
    endtask

    task automatic run_txn(input string tag, input logic [31:0] addr, input int len, input int early,
                           input bit rnd, input int hold, input int est, input int encmd,
                           input int enbeat, input int encons);
        logic [9:0]   l10;
        logic [95:0]  meta;
        logic [127:0] key;
        logic [31:0]  c_addr;
        logic [9:0]   c_len;
        logic [159:0] got_cpl;
        bit           got_last [128];
        logic [511:0] got_beats [128];
        int n_offer, j, cyc, ncmd, nbeat, nact, viol, acc_cyc, cpl_cyc, seen;
        bit accepted, done;

        l10 = len[9:0];
        for (int k = 0; k < 3; k++) meta[k*32 +: 32] = $urandom;
        for (int k = 0; k < 4; k++) key[k*32 +: 32] = $urandom;
        n_offer = (len == 0) ? 1 : (early >= 0) ? early + 1 : (len + 7) / 8;
        for (int i = 0; i < 128; i++)
            for (int k = 0; k < 16; k++) vals[i][k*32 +: 32] = $urandom;

        j = 0; cyc = 0; ncmd = 0; nbeat = 0; nact = 0; viol = 0; seen = 0;
        acc_cyc = -1; cpl_cyc = -1; accepted = 0; done = 0;
        c_addr = '0; c_len = '0; got_cpl = '0;

        while (!done && cyc < 2000) begin
            @(negedge clk);
            input_valid   = !accepted;
            input_data    = {l10, addr, meta, key};
            value_valid   = (j < n_offer) && (!rnd || $urandom_range(0, 3) != 0);
            value_data    = vals[j % 128];
            value_last    = (j == n_offer - 1);
            wr_cmd_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            wr_data_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cpl_ready     = cpl_valid && (seen >= hold);
            #1;
            if (cpl_valid) begin
                seen++;
                if (cpl_cyc < 0) cpl_cyc = cyc;
            end
            if (accepted && input_ready) viol++;
            if (wr_cmd_valid || wr_data_valid) nact++;
            if (input_valid && input_ready) begin accepted = 1; acc_cyc = cyc; end
            if (value_valid && value_ready) j++;
            if (wr_cmd_valid && wr_cmd_ready) begin ncmd++; c_addr = wr_cmd_addr; c_len = wr_cmd_len; end
            if (wr_data_valid && wr_data_ready) begin
                if (nbeat < 128) begin got_beats[nbeat] = wr_data; got_last[nbeat] = wr_data_last; end
                nbeat++;
            end
            if (cpl_valid && cpl_ready) begin got_cpl = cpl_data; done = 1; end
            @(posedge clk);
            cyc++;
        end
        @(negedge clk);
        input_valid = 0; value_valid = 0; value_last = 0; cpl_ready = 0;

        chk({tag, ".done"}, 512'(done), 512'(1));
        chk({tag, ".ncmd"}, 512'(ncmd), 512'(encmd));
        if (encmd > 0) begin
            chk({tag, ".cmd_addr"}, 512'(c_addr), 512'(addr));
            chk({tag, ".cmd_len"}, 512'(c_len), 512'(l10));
        end else begin
            chk({tag, ".wr_activity"}, 512'(nact), 512'(0));
        end
        chk({tag, ".nbeat"}, 512'(nbeat), 512'(enbeat));
        for (int i = 0; i < nbeat && i < enbeat && i < 128; i++) begin
            chk($sformatf("%s.beat%0d", tag, i), got_beats[i], exp_beat(i, len, early));
            chk($sformatf("%s.last%0d", tag, i), 512'(got_last[i]), 512'(i == enbeat - 1));
        end
        chk({tag, ".consumed"}, 512'(j), 512'(encons));
        chk({tag, ".cpl_status"}, 512'(got_cpl[31:16]), 512'(est));
        chk({tag, ".cpl_len"}, 512'(got_cpl[41:32]), 512'(l10));
        chk({tag, ".cpl_meta"}, 512'(got_cpl[159:64]), 512'(meta));
        chk({tag, ".cpl_fixed"}, 512'({got_cpl[63:42], got_cpl[15:0]}), 512'({22'h0, 16'hffff}));
        chk({tag, ".in_rdy_held"}, 512'(viol), 512'(0));
        if (len == 0) chk({tag, ".cpl_latency_le2"}, 512'((cpl_cyc - acc_cyc) <= 2), 512'(1));
    endtask

    initial begin
        int st, nc, nb, ncs, len, early;
        logic [31:0] addr;

        vecs.push_back('{32'h100,  16,   -1, 0, 0,  0, 1, 2,   2});
        vecs.push_back('{32'h40,   5,    -1, 0, 0,  0, 1, 1,   1});
        vecs.push_back('{32'h80,   0,    -1, 0, 0,  0, 0, 0,   0});
        vecs.push_back('{32'h0,    24,   -1, 0, 0,  1, 0, 0,   3});
        vecs.push_back('{32'h1000, 40,   -1, 1, 10, 0, 1, 5,   5});
        vecs.push_back('{32'h2000, 8,    -1, 1, 3,  0, 1, 1,   1});
        vecs.push_back('{32'h3000, 1,    -1, 0, 0,  0, 1, 1,   1});
        vecs.push_back('{32'h3008, 1023, -1, 0, 2,  0, 1, 128, 128});
`ifdef MUU_SET_LENCHECK_EN
        vecs.push_back('{32'h500,  24,   1,  0, 0,  2, 1, 3,   2});
`endif

        rst_n = 0; input_valid = 0; input_data = '0; value_valid = 0; value_data = '0;
        value_last = 0; wr_cmd_ready = 0; wr_data_ready = 0; cpl_ready = 0;
        #3;
        chk("rst.input_ready", 512'(input_ready), 512'(0));
        chk("rst.value_ready", 512'(value_ready), 512'(0));
        chk("rst.wr_cmd_valid", 512'(wr_cmd_valid), 512'(0));
        chk("rst.wr_data_valid", 512'(wr_data_valid), 512'(0));
        chk("rst.wr_data_last", 512'(wr_data_last), 512'(0));
        chk("rst.cpl_valid", 512'(cpl_valid), 512'(0));
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        #1;
        chk("post_rst.input_ready", 512'(input_ready), 512'(1));

        foreach (vecs[v])
            run_txn($sformatf("vec%0d", v), vecs[v].addr, vecs[v].len, vecs[v].early, vecs[v].rnd,
                    vecs[v].hold, vecs[v].st, vecs[v].ncmd, vecs[v].nbeat, vecs[v].ncons);

        // Reset asserted while a beat is parked in the output register
        @(negedge clk);
        input_valid   = 1;
        input_data    = {10'd24, 32'h200, 96'h1, 128'h2};
        value_valid   = 1;
        value_data    = {16{32'h5a5a_0001}};
        value_last    = 0;
        wr_cmd_ready  = 1;
        wr_data_ready = 0;
        @(negedge clk);
        input_valid = 0;
        repeat (5) @(negedge clk);
        #1;
        chk("mid.wr_data_valid", 512'(wr_data_valid), 512'(1));
        rst_n = 0;
        #1;
        chk("mid_rst.valids", 512'({input_ready, value_ready, wr_cmd_valid, wr_data_valid,
                                    wr_data_last, cpl_valid}), 512'(0));
        @(negedge clk);
        value_valid = 0; wr_cmd_ready = 0;
        rst_n = 1;
        @(negedge clk);
        run_txn("after_rst", 32'h240, 12, -1, 0, 0, 0, 1, 2, 2);

        for (int r = 0; r < 30; r++) begin
            addr  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            len   = $urandom_range(0, 100);
            early = -1;
            model(addr, len, early, st, nc, nb, ncs);
            run_txn($sformatf("rnd%0d", r), addr, len, early, 1, $urandom_range(0, 4), st, nc, nb, ncs);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
